// File: rtl/dec_hazard_ctrl.sv
// dec_hazard_ctrl: decode-stage issue controller.
// Tracks pending long-latency register writes (loads cleared by LSU
// response, mul/div cleared after MULDIV_LAT cycles). It also drives
// stall/bubble/issue for the fetch/decode flops and sequences a
// post-flush refill window.
// Optional build macro SB_BYPASS_EN: the hazard check ignores scoreboard
// bits that are being cleared in the current cycle, so a dependent
// instruction can issue in the clearing cycle.
module dec_hazard_ctrl #(
    parameter int unsigned MULDIV_LAT   = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid_i,
    input  logic        dec_rs1_v_i,
    input  logic [4:0]  dec_rs1_adr_i,
    input  logic        dec_rs2_v_i,
    input  logic [4:0]  dec_rs2_adr_i,
    input  logic        dec_rd_v_i,
    input  logic [4:0]  dec_rd_adr_i,
    input  logic        dec_is_load_i,
    input  logic        dec_is_muldiv_i,
    input  logic        lsu_rsp_v_i,
    input  logic [4:0]  lsu_rsp_rd_adr_i,
    input  logic        flush_v_i,
    output logic        issue_o,
    output logic        stall_o,
    output logic        bubble_o,
    output logic        muldiv_busy_o,
    output logic [31:0] scoreboard_q_o,
    output logic [1:0]  state_q_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_sb;
    logic [31:0] w_sb_nxt;
    logic [31:0] w_clr;
    logic [31:0] w_set;
    logic [31:0] w_sb_chk;
    logic [3:0]  r_md_cnt;
    logic [4:0]  r_md_rd;
    logic        r_md_rd_v;
    logic [2:0]  r_fl_cnt;
    logic [2:0]  w_fl_cnt_nxt;
    logic        w_hazard;
    logic        w_md_busy;
    logic        w_issue;
    logic        w_stall;
    logic        w_bubble;

    // Clear vector for this cycle and the RAW/WAW/structural hazard check
    always_comb begin
        w_clr = '0;
        if (lsu_rsp_v_i) begin
            w_clr[lsu_rsp_rd_adr_i] = 1'b1;
        end
        if (r_md_cnt == 4'd1 && r_md_rd_v) begin
            w_clr[r_md_rd] = 1'b1;
        end
`ifdef SB_BYPASS_EN
        w_sb_chk = r_sb & ~w_clr;
`else
        w_sb_chk = r_sb;
`endif
        w_md_busy = (r_md_cnt != '0);
        w_hazard  = (dec_rs1_v_i && (dec_rs1_adr_i != '0) && w_sb_chk[dec_rs1_adr_i])
                 || (dec_rs2_v_i && (dec_rs2_adr_i != '0) && w_sb_chk[dec_rs2_adr_i])
                 || (dec_rd_v_i  && (dec_rd_adr_i  != '0) && w_sb_chk[dec_rd_adr_i])
                 || (dec_is_muldiv_i && w_md_busy);
    end

    // Next-state and issue/stall/bubble decode
    always_comb begin
        w_state_nxt  = r_state;
        w_fl_cnt_nxt = r_fl_cnt;
        w_issue      = 1'b0;
        w_stall      = 1'b0;
        w_bubble     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_stall     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (flush_v_i) begin
                    w_state_nxt  = ST_FLUSH;
                    w_fl_cnt_nxt = 3'(FLUSH_CYCLES);
                end else begin
                    w_issue  = dec_valid_i & ~w_hazard;
                    w_stall  = dec_valid_i &  w_hazard;
                    w_bubble = ~w_issue;
                end
            end
            ST_FLUSH: begin
                if (flush_v_i) begin
                    w_fl_cnt_nxt = 3'(FLUSH_CYCLES);
                end else begin
                    w_fl_cnt_nxt = r_fl_cnt - 3'd1;
                    if (r_fl_cnt == 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Scoreboard update: clears first, then sets so a same-index set wins
    always_comb begin
        w_set = '0;
        if (w_issue && dec_rd_v_i && (dec_rd_adr_i != '0)
            && (dec_is_load_i || dec_is_muldiv_i)) begin
            w_set[dec_rd_adr_i] = 1'b1;
        end
        w_sb_nxt    = (r_sb & ~w_clr) | w_set;
        w_sb_nxt[0] = 1'b0;
    end

    // State, flush counter and scoreboard registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_fl_cnt <= '0;
            r_sb     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_fl_cnt <= w_fl_cnt_nxt;
            r_sb     <= w_sb_nxt;
        end
    end

    // Mul/div latency counter and tracked destination
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt  <= '0;
            r_md_rd   <= '0;
            r_md_rd_v <= 1'b0;
        end else if (w_issue && dec_is_muldiv_i) begin
            r_md_cnt  <= 4'(MULDIV_LAT);
            r_md_rd   <= dec_rd_adr_i;
            r_md_rd_v <= dec_rd_v_i && (dec_rd_adr_i != '0);
        end else if (r_md_cnt != '0) begin
            r_md_cnt  <= r_md_cnt - 4'd1;
        end
    end

    assign issue_o        = w_issue;
    assign stall_o        = w_stall;
    assign bubble_o       = w_bubble;
    assign muldiv_busy_o  = w_md_busy;
    assign scoreboard_q_o = r_sb;
    assign state_q_o      = r_state;

endmodule
